// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared types and helpers for the fetch/realign stage
package rv32_pkg;

  typedef logic [15:0] halfword_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic is_rvc(halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rv32_mod_fetch_aligner_if.sv
// rtl/rv32_mod_fetch_aligner_if.sv - memory fetch bus and instruction output bus
interface rv32_mod_fetch_aligner_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_compressed;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc, inst_compressed,
    input  mem_ack, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, inst_compressed,
    output mem_ack, mem_rdata, inst_ready
  );

endinterface

// File: rtl/rv32_mod_halfword_queue.sv
// rtl/rv32_mod_halfword_queue.sv - 4-entry halfword FIFO, 0..2 pushes and pops per cycle
module rv32_mod_halfword_queue
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [1:0] push_cnt,
  input  halfword_t  push_lo,
  input  halfword_t  push_hi,
  input  logic [1:0] pop_cnt,
  output halfword_t  head0,
  output halfword_t  head1,
  output logic [2:0] count
);

  halfword_t  q      [4];
  halfword_t  q_next [4];
  logic [2:0] remain;
  logic [2:0] remain_p1;
  logic [2:0] count_next;

  // Entry 0 is always the head: pop shifts down, pushes land after the survivors.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_next[i] = q[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (i + int'(pop_cnt) < 4) begin
        q_next[i] = q[2'(i + int'(pop_cnt))];
      end
    end
    remain    = count - {1'b0, pop_cnt};
    remain_p1 = remain + 3'd1;
    for (int i = 0; i < 4; i++) begin
      if (push_cnt != 2'd0 && 3'(i) == remain) begin
        q_next[i] = push_lo;
      end
      if (push_cnt == 2'd2 && 3'(i) == remain_p1) begin
        q_next[i] = push_hi;
      end
    end
    count_next = flush ? 3'd0 : remain + {1'b0, push_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        q[i] <= '0;
      end
    end else begin
      count <= count_next;
      for (int i = 0; i < 4; i++) begin
        q[i] <= q_next[i];
      end
    end
  end

  assign head0 = q[0];
  assign head1 = q[1];

endmodule

// File: rtl/rv32_mod_fetch_aligner.sv
// rtl/rv32_mod_fetch_aligner.sv - word fetch and RVC/32-bit instruction realignment
module rv32_mod_fetch_aligner
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  rv32_mod_fetch_aligner_if.master   bus
);

  localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] RESET_HALF = {RESET_PC[31:1], 1'b0};

  fetch_state_e state, state_next;
  logic [31:0]  mem_addr_q, mem_addr_next;
  logic [31:0]  redir_addr_q, redir_addr_next;
  logic [31:0]  pc_q, pc_next;
  logic         skip_low_q, skip_low_next;

  halfword_t    head0, head1, push_lo, push_hi;
  logic [2:0]   count, after_pop;
  logic [1:0]   push_cnt, pop_cnt;
  logic         head_rvc, inst_valid, fire;

  rv32_mod_halfword_queue u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push_cnt (push_cnt),
    .push_lo  (push_lo),
    .push_hi  (push_hi),
    .pop_cnt  (pop_cnt),
    .head0    (head0),
    .head1    (head1),
    .count    (count)
  );

  // A redirect in the same cycle cancels any handshake on the output side.
  always_comb begin
    head_rvc   = is_rvc(head0);
    inst_valid = (count != 3'd0) && (head_rvc || count >= 3'd2);
    fire       = inst_valid && bus.inst_ready && !redirect_valid;
    pop_cnt    = fire ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
    after_pop  = count - {1'b0, pop_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      mem_addr_q   <= RESET_WORD;
      redir_addr_q <= RESET_WORD;
      pc_q         <= RESET_HALF;
      skip_low_q   <= RESET_PC[1];
    end else begin
      state        <= state_next;
      mem_addr_q   <= mem_addr_next;
      redir_addr_q <= redir_addr_next;
      pc_q         <= pc_next;
      skip_low_q   <= skip_low_next;
    end
  end

  always_comb begin
    state_next      = state;
    mem_addr_next   = mem_addr_q;
    redir_addr_next = redir_addr_q;
    skip_low_next   = skip_low_q;
    pc_next         = fire ? pc_q + (head_rvc ? 32'd2 : 32'd4) : pc_q;
    push_cnt        = 2'd0;
    push_lo         = skip_low_q ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    push_hi         = bus.mem_rdata[31:16];

    case (state)
      RUN: begin
        if (after_pop <= 3'd2) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_next    = RUN;
          push_cnt      = skip_low_q ? 2'd1 : 2'd2;
          mem_addr_next = mem_addr_q + 32'd4;
          skip_low_next = 1'b0;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          state_next    = RUN;
          mem_addr_next = redir_addr_q;
        end
      end
      default: state_next = RUN;
    endcase

    // An in-flight request must keep its address, so the new target parks in
    // redir_addr until the stale response has been swallowed in DROP.
    if (redirect_valid) begin
      push_cnt      = 2'd0;
      pc_next       = {redirect_pc[31:1], 1'b0};
      skip_low_next = redirect_pc[1];
      if (state == RUN || bus.mem_ack) begin
        state_next    = RUN;
        mem_addr_next = {redirect_pc[31:2], 2'b00};
      end else begin
        state_next      = DROP;
        mem_addr_next   = mem_addr_q;
        redir_addr_next = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  assign bus.mem_req         = (state != RUN);
  assign bus.mem_addr        = mem_addr_q;
  assign bus.inst_valid      = inst_valid;
  assign bus.inst_data       = head_rvc ? {16'h0000, head0} : {head1, head0};
  assign bus.inst_pc         = pc_q;
  assign bus.inst_compressed = head_rvc;

endmodule
